// File: rtl/fetch_stage_pkg.sv
// Shared LC-3b types for the fetch stage: machine word, opcode field and
// fetch FSM state encoding, plus a helper that forces word alignment.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic lc3b_word word_align(input lc3b_word a);
    return {a[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: valid/instr/pc with clear (priority) and load.
// Clear empties the slot to a NOP but leaves pc untouched.
module ifid_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  logic     clear,
  input  lc3b_word next_instr,
  input  lc3b_word next_pc,
  output logic     valid,
  output lc3b_word instr,
  output lc3b_word pc
);

  // Register update: clear beats load, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      instr <= 16'h0000;
      pc    <= 16'h0000;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= 16'h0000;
    end else if (load) begin
      valid <= 1'b1;
      instr <= next_instr;
      pc    <= next_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LC-3b instruction fetch stage: owns the PC, runs the imem read handshake
// and feeds decode through the IF/ID register.
//
//   state | meaning
//   FETCH | read outstanding at pc; accept response into IF/ID or buffer
//   DRAIN | redirect arrived mid-read; wait out the stale response
//   HOLD  | response parked in buffer while decode is stalled; no read
module fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [3:0]  id_opcode,
  output logic [2:0]  id_bits4_5_11
);

  fetch_state_t state, next_state;
  lc3b_word     pc, target, buf_instr, buf_pc;
  lc3b_word     pc_plus2, redirect_tgt, pc_next;
  lc3b_word     ifid_d_instr, ifid_d_pc;
  logic         active, resp, ld;
  logic         ifid_load, ifid_clear, pc_load, target_load, buf_load;

  // active holds off the first request until the first edge after reset
  assign imem_read    = active && (state != HOLD);
  assign imem_address = pc;
  assign resp         = imem_resp && imem_read;
  assign ld           = !stall || !id_valid;
  assign pc_plus2     = pc + 16'd2;
  assign redirect_tgt = word_align(redirect_pc);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (redirect_valid) next_state = resp ? FETCH : DRAIN;
        else if (resp && !ld) next_state = HOLD;
      end
      DRAIN:   if (resp) next_state = FETCH;
      HOLD:    if (redirect_valid || !stall) next_state = FETCH;
      default: next_state = FETCH;
    endcase
  end

  // Datapath control per state; redirect always flushes IF/ID
  always_comb begin
    ifid_load    = 1'b0;
    ifid_clear   = 1'b0;
    ifid_d_instr = imem_rdata;
    ifid_d_pc    = pc_plus2;
    pc_load      = 1'b0;
    pc_next      = pc_plus2;
    target_load  = 1'b0;
    buf_load     = 1'b0;
    case (state)
      FETCH: begin
        if (redirect_valid) begin
          ifid_clear = 1'b1;
          if (resp) begin
            pc_load = 1'b1;
            pc_next = redirect_tgt;
          end else begin
            target_load = 1'b1;
          end
        end else if (resp) begin
          pc_load = 1'b1;
          if (ld) ifid_load = 1'b1;
          else    buf_load  = 1'b1;
        end else if (ld) begin
          ifid_clear = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          ifid_clear  = 1'b1;
          target_load = 1'b1;
        end else if (ld) begin
          ifid_clear = 1'b1;
        end
        if (resp) begin
          pc_load = 1'b1;
          pc_next = redirect_valid ? redirect_tgt : target;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          ifid_clear = 1'b1;
          pc_load    = 1'b1;
          pc_next    = redirect_tgt;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_d_instr = buf_instr;
          ifid_d_pc    = buf_pc;
        end
      end
      default: ;
    endcase
  end

  // PC, redirect target, stall buffer and request enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= word_align(RESET_PC);
      target    <= 16'h0000;
      buf_instr <= 16'h0000;
      buf_pc    <= 16'h0000;
      active    <= 1'b0;
    end else begin
      active <= 1'b1;
      if (pc_load)     pc     <= pc_next;
      if (target_load) target <= redirect_tgt;
      if (buf_load) begin
        buf_instr <= imem_rdata;
        buf_pc    <= pc_plus2;
      end
    end
  end

  ifid_reg u_ifid (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (ifid_load),
    .clear      (ifid_clear),
    .next_instr (ifid_d_instr),
    .next_pc    (ifid_d_pc),
    .valid      (id_valid),
    .instr      (id_instr),
    .pc         (id_pc)
  );

  assign id_opcode     = id_instr[15:12];
  assign id_bits4_5_11 = {id_instr[11], id_instr[5], id_instr[4]};

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed cycle checks followed by a randomized
// phase. A memory model answers reads with variable latency; a scoreboard of
// expected (instr, pc) pairs is rebuilt from each stream start (reset or
// redirect) and popped whenever decode accepts an instruction.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [3:0]  id_opcode;
  logic [2:0]  id_bits4_5_11;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  int   lat = 0;
  int   lat_fixed = 0;
  exp_t sb[$];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_opcode      (id_opcode),
    .id_bits4_5_11  (id_bits4_5_11)
  );

  always #5 clk = ~clk;

  // Program image: two fixed words at the reset vector, hashed contents elsewhere
  function automatic logic [15:0] mem(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1261;
    if (a == 16'h0002) return 16'h5020;
    return ({a[7:0], a[15:8]} ^ 16'h9C3B) + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected program-order stream starting at a word-aligned address
  task automatic gen(input logic [15:0] start);
    logic [15:0] a;
    exp_t e;
    sb.delete();
    a = start & 16'hFFFE;
    repeat (600) begin
      e.instr = mem(a);
      e.pc    = a + 16'd2;
      sb.push_back(e);
      a = a + 16'd2;
    end
  endtask

  // Memory model: responds after lat idle cycles, junk data outside resp
  initial begin
    imem_resp  = 1'b0;
    imem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        imem_resp = 1'b0;
        lat = 0;
      end else if (imem_read) begin
        if (lat == 0) begin
          imem_resp  = 1'b1;
          imem_rdata = mem(imem_address);
          lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
        end else begin
          imem_resp  = 1'b0;
          imem_rdata = 16'hDEAD;
          lat--;
        end
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = 16'hDEAD;
      end
    end
  end

  // Monitor: request stability and scoreboard pop on each accepted instruction
  initial begin
    logic        prev_pend;
    logic [15:0] prev_addr;
    exp_t        e;
    prev_pend = 1'b0;
    prev_addr = 16'h0000;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) chk("addr_hold", {15'd0, imem_read, imem_address}, {15'd0, 1'b1, prev_addr});
        if (imem_read) chk("addr_even", {31'd0, imem_address[0]}, 32'd0);
        prev_pend = imem_read && !imem_resp;
        prev_addr = imem_address;
        if (id_valid && !stall && !redirect_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty: got id_pc %h, expected nothing pending", id_pc);
          end else begin
            e = sb.pop_front();
            n_pop++;
            chk("sb_instr", {16'd0, id_instr}, {16'd0, e.instr});
            chk("sb_pc", {16'd0, id_pc}, {16'd0, e.pc});
            chk("sb_opcode", {28'd0, id_opcode}, {28'd0, e.instr[15:12]});
            chk("sb_bits", {29'd0, id_bits4_5_11}, {29'd0, e.instr[11], e.instr[5], e.instr[4]});
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  // Directed sequence then randomized traffic
  initial begin
    reset_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    lat_fixed = 0;
    #2;
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", {16'd0, id_instr}, 32'd0);
    chk("rst_pc", {16'd0, id_pc}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    gen(RST_PC);
    #1;
    chk("pre_first_read", {31'd0, imem_read}, 32'd0);

    @(negedge clk); // C0
    chk("c0_read", {31'd0, imem_read}, 32'd1);
    chk("c0_addr", {16'd0, imem_address}, 32'h0000);
    @(negedge clk); // C1
    chk("c1_valid", {31'd0, id_valid}, 32'd1);
    chk("c1_instr", {16'd0, id_instr}, 32'h1261);
    chk("c1_pc", {16'd0, id_pc}, 32'h0002);
    chk("c1_opcode", {28'd0, id_opcode}, 32'h1);
    chk("c1_bits", {29'd0, id_bits4_5_11}, 32'b010);
    chk("c1_addr", {16'd0, imem_address}, 32'h0002);
    @(posedge clk); #1; stall = 1'b1; // C2
    @(negedge clk);
    chk("c2_instr", {16'd0, id_instr}, 32'h5020);
    chk("c2_pc", {16'd0, id_pc}, 32'h0004);
    chk("c2_addr", {16'd0, imem_address}, 32'h0004);
    for (int i = 0; i < 2; i++) begin // C3, C4
      @(negedge clk);
      chk("hold_read", {31'd0, imem_read}, 32'd0);
      chk("hold_instr", {16'd0, id_instr}, 32'h5020);
      chk("hold_pc", {16'd0, id_pc}, 32'h0004);
    end
    @(posedge clk); #1; stall = 1'b0; // C5
    @(negedge clk);
    chk("c5_instr", {16'd0, id_instr}, 32'h5020);
    lat = 2;
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 16'h3001; gen(16'h3001); // C6
    @(negedge clk);
    chk("unstall_instr", {16'd0, id_instr}, {16'd0, mem(16'h0004)});
    chk("unstall_pc", {16'd0, id_pc}, 32'h0006);
    chk("c6_addr", {16'd0, imem_address}, 32'h0006);
    @(posedge clk); #1; redirect_valid = 1'b0; // C7
    @(negedge clk);
    chk("drain_addr", {15'd0, imem_read, imem_address}, {15'd0, 1'b1, 16'h0006});
    chk("drain_valid", {31'd0, id_valid}, 32'd0);
    chk("drain_instr", {16'd0, id_instr}, 32'd0);
    @(negedge clk); // C8
    chk("drain_resp_addr", {16'd0, imem_address}, 32'h0006);
    chk("drain_resp_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk); // C9
    chk("redir_addr", {16'd0, imem_address}, 32'h3000);
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
    @(posedge clk); #1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100; gen(16'h0100); // C10
    @(negedge clk);
    chk("c10_instr", {16'd0, id_instr}, {16'd0, mem(16'h3000)});
    chk("c10_pc", {16'd0, id_pc}, 32'h3002);
    @(posedge clk); #1; stall = 1'b0; redirect_valid = 1'b0; // C11
    @(negedge clk);
    chk("rs_valid", {31'd0, id_valid}, 32'd0);
    chk("rs_instr", {16'd0, id_instr}, 32'd0);
    chk("rs_addr", {16'd0, imem_address}, 32'h0100);
    @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 16'hFFFE; gen(16'hFFFE); // C12
    @(negedge clk);
    @(posedge clk); #1; redirect_valid = 1'b0; // C13
    @(negedge clk);
    chk("wrap_addr0", {16'd0, imem_address}, 32'hFFFE);
    @(negedge clk); // C14
    chk("wrap_valid", {31'd0, id_valid}, 32'd1);
    chk("wrap_pc", {16'd0, id_pc}, 32'h0000);
    chk("wrap_instr", {16'd0, id_instr}, {16'd0, mem(16'hFFFE)});
    chk("wrap_addr1", {16'd0, imem_address}, 32'h0000);
    lat = 2;
    @(posedge clk); #3; reset_n = 1'b0; // C15, mid-request
    #1;
    chk("arst_read", {31'd0, imem_read}, 32'd0);
    chk("arst_valid", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    gen(RST_PC);
    @(negedge clk);
    chk("restart_read", {31'd0, imem_read}, 32'd1);
    chk("restart_addr", {16'd0, imem_address}, {16'd0, RST_PC});

    lat_fixed = -1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 23) == 0);
      redirect_pc = 16'($urandom);
      if (redirect_valid) gen(redirect_pc);
    end
    @(posedge clk);
    #1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("progress", {31'd0, (n_pop > 100)}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- LC-3b pipeline instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of decode.
- Owns the PC and drives the instruction-memory read handshake.
- Presents the latched instruction to decode: full word, opcode, and the decode select bits {ir[11], ir[5], ir[4]}.
- Accepts stall from the hazard logic and redirect (taken branch/JMP/JSR/TRAP target) from the resolving stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_read  out  1  instruction read request
- imem_address  out  16  read address, bit0 always 0
- imem_rdata  in  16  read data, valid when imem_resp=1
- imem_resp  in  1  single-cycle read completion
- stall  in  1  decode cannot accept; IF/ID holds
- redirect_valid  in  1  single-cycle PC redirect; also flushes IF/ID
- redirect_pc  in  16  redirect target
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  16  latched instruction
- id_pc  out  16  address of latched instruction + 2
- id_opcode  out  4  id_instr[15:12]
- id_bits4_5_11  out  3  {id_instr[11], id_instr[5], id_instr[4]}

Behaviour:
- Reset (async, while reset_n=0):
  - pc=RESET_PC, state=FETCH, imem_read=0.
  - id_valid=0, id_instr=16'h0000 (BR nzp=000, a NOP), id_pc=0, buffer empty.
  - First request is issued in the first cycle after reset_n rises.
- Memory protocol:
  - imem_read and imem_address are held stable from assertion until the imem_resp cycle.
  - Data is sampled in the resp cycle.
  - A new request may be issued in the very next cycle (back-to-back).
- IF/ID load enable: ld = !stall || !id_valid.
- State FETCH (imem_read=1, imem_address=pc):
  - resp & !redirect & ld: IF/ID <= {valid=1, rdata, pc+2}; pc <= pc+2; stay FETCH.
  - resp & !redirect & !ld: buffer <= {rdata, pc+2}; pc <= pc+2; go HOLD.
  - resp & redirect: discard rdata; pc <= redirect_pc & 16'hFFFE; stay FETCH.
  - !resp & redirect: target <= redirect_pc & 16'hFFFE; go DRAIN.
- State DRAIN (imem_read=1, address = old pc):
  - A further redirect overwrites target.
  - On resp: discard data; pc <= target (or the new redirect_pc if it arrives the same cycle); go FETCH.
- State HOLD (imem_read=0):
  - !stall & !redirect: IF/ID <= buffer; go FETCH.
  - redirect: drop buffer; pc <= redirect_pc & 16'hFFFE; go FETCH.
- IF/ID update rules:
  - Any cycle with redirect_valid: id_valid <= 0, id_instr <= 0, regardless of stall. Redirect has priority over stall and resp.
  - ld=1 and no new instruction: id_valid <= 0, id_instr <= 0 (decode consumed it).
  - ld=0: all IF/ID fields hold.
- PC arithmetic: 16-bit modulo, so 16'hFFFE + 2 = 16'h0000. id_pc wraps the same way.
- Decode fields:
  - id_opcode and id_bits4_5_11 are combinational slices of id_instr; no added latency.
- Latency: imem_resp in cycle N makes the instruction visible on id_* in cycle N+1 (given ld=1).
- Reset asserted mid-access: imem_read drops immediately. The outstanding response, if any, is ignored because the memory is also reset.

Decomposition:
- lc3b_types: add fetch_state_t enum {FETCH, DRAIN, HOLD}. Reuse lc3b_word and lc3b_opcode.
- Sub-module ifid_reg: valid/instr/pc register with load, clear, async active-low reset.
- The FSM and PC live in fetch_stage.

Test Plan:
- Reset release, imem_resp every cycle, rdata=16'h1261, 16'h5020, ...
  -> addresses 0000, 0002, 0004 on consecutive cycles.
  -> id_instr=1261/id_pc=0002, then 5020/0004.
  -> id_opcode=4'h1, id_bits4_5_11=3'b010 for 1261.
- stall=1 for 3 cycles with id_valid=1 while resp arrives
  -> state HOLD, imem_read=0, id_* unchanged.
  -> on stall release, buffered word appears next cycle with the correct id_pc; no instruction lost or duplicated.
- redirect_valid with redirect_pc=16'h3001 while a request to 0006 is pending 2 more cycles
  -> address stays 0006 until resp, that data is discarded.
  -> next address 3000; id_valid=0, id_instr=0000 meanwhile.
- redirect_valid in the same cycle as resp and stall=1
  -> rdata dropped, IF/ID cleared (id_valid=0), next address = target.
- PC at 16'hFFFE, resp
  -> id_pc=16'h0000, next address 16'h0000.
- reset_n pulsed low mid-request
  -> imem_read=0 and id_valid=0 asynchronously; after release, fetch restarts at RESET_PC.
